// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single sdram controller port between three requesters
// (0 video fetch, 1 CPC core RAM, 2 support CPU/DMA). One access in flight at a time.
// The grant is registered, so ack_o appears one cycle after the request is seen and
// the rd/wr strobe follows one cycle later. Returned read data goes to the owning port.
// Build option: define SDRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed
// priority 0 > 1 > 2.
module sdram_arbiter #(
   parameter int AW         = 23,
   parameter int WR_CYCLES  = 8,
   parameter int RD_TIMEOUT = 31
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [2:0]        req_i,
   input  logic [2:0]        we_i,
   input  logic [3*AW-1:0]   addr_i,
   input  logic [47:0]       wdata_i,
   input  logic [5:0]        dm_i,
   output logic [2:0]        ack_o,
   output logic [15:0]       rdata_o,
   output logic [2:0]        rvalid_o,
   output logic              err_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [AW-1:0]     mem_A_o,
   output logic [15:0]       mem_D_o,
   output logic [1:0]        mem_Dm_o,
   input  logic [15:0]       mem_D_i,
   input  logic              mem_valid_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;

   // Counter compare values, sized to the 8-bit wait counter.
   localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT);
   localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);

   state_t          state_q, state_d;
   logic [1:0]      owner_q, owner_d;
   logic            we_q, we_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [2:0]      ack_q, ack_d;
   logic [2:0]      rvalid_q, rvalid_d;
   logic            mem_rd_q, mem_rd_d;
   logic            mem_wr_q, mem_wr_d;
   logic [AW-1:0]   mem_a_q, mem_a_d;
   logic [15:0]     mem_d_q, mem_d_d;
   logic [1:0]      mem_dm_q, mem_dm_d;
   logic [15:0]     rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [1:0]      win;
`ifdef SDRAM_ARB_RR_EN
   logic [1:0]      last_grant_q, last_grant_d;
   logic [1:0]      p0, p1, p2;
`endif

   // Per-port views of the packed request fields.
   logic [AW-1:0]   port_addr  [3];
   logic [15:0]     port_wdata [3];
   logic [1:0]      port_dm    [3];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_port
         assign port_addr[gi]  = addr_i[gi*AW +: AW];
         assign port_wdata[gi] = wdata_i[gi*16 +: 16];
         assign port_dm[gi]    = dm_i[gi*2 +: 2];
      end
   endgenerate

   // Winner selection; later assignments override earlier ones, so the first
   // port in search order that is requesting wins.
   always_comb begin
      win = 2'd0;
`ifdef SDRAM_ARB_RR_EN
      p0 = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
      p1 = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
      p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
      if (req_i[p2]) win = p2;
      if (req_i[p1]) win = p1;
      if (req_i[p0]) win = p0;
`else
      if (req_i[2]) win = 2'd2;
      if (req_i[1]) win = 2'd1;
      if (req_i[0]) win = 2'd0;
`endif
   end

   // Next-state and registered-output logic for the access FSM.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      ack_d    = 3'b000;
      rvalid_d = 3'b000;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      mem_a_d  = mem_a_q;
      mem_d_d  = mem_d_q;
      mem_dm_d = mem_dm_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
`ifdef SDRAM_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_i != 3'b000) begin
               owner_d     = win;
               we_d        = we_i[win];
               mem_a_d     = port_addr[win];
               mem_d_d     = port_wdata[win];
               mem_dm_d    = port_dm[win];
               ack_d[win]  = 1'b1;
               state_d     = ISSUE;
`ifdef SDRAM_ARB_RR_EN
               last_grant_d = win;
`endif
            end
         end
         ISSUE: begin
            mem_rd_d = ~we_q;
            mem_wr_d = we_q;
            cnt_d    = 8'd0;
            state_d  = we_q ? WAIT_WR : WAIT_RD;
         end
         WAIT_RD: begin
            // Data arriving on the timeout cycle still counts as a good read.
            if (mem_valid_i) begin
               rdata_d           = mem_D_i;
               rvalid_d[owner_q] = 1'b1;
               state_d           = IDLE;
            end else if (cnt_q == RD_LAST) begin
               rdata_d           = 16'hFFFF;
               rvalid_d[owner_q] = 1'b1;
               err_d             = 1'b1;
               state_d           = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         WAIT_WR: begin
            if (cnt_q == WR_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset drops any access in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         owner_q  <= 2'd0;
         we_q     <= 1'b0;
         cnt_q    <= 8'd0;
         ack_q    <= 3'b000;
         rvalid_q <= 3'b000;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         mem_a_q  <= '0;
         mem_d_q  <= 16'h0000;
         mem_dm_q <= 2'b00;
         rdata_q  <= 16'h0000;
         err_q    <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
         last_grant_q <= 2'd2;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         rvalid_q <= rvalid_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
         mem_a_q  <= mem_a_d;
         mem_d_q  <= mem_d_d;
         mem_dm_q <= mem_dm_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
`ifdef SDRAM_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign ack_o    = ack_q;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
   assign mem_rd_o = mem_rd_q;
   assign mem_wr_o = mem_wr_q;
   assign mem_A_o  = mem_a_q;
   assign mem_D_o  = mem_d_q;
   assign mem_Dm_o = mem_dm_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter: a table of single-port transactions plus
// hand-written sequences for write spacing, reset mid-read, spurious mem_valid_i
// and arbitration order with all ports requesting.
module tb_sdram_arbiter;

   localparam int AW         = 23;
   localparam int WR_CYCLES  = 8;
   localparam int RD_TIMEOUT = 31;

   logic              clk = 1'b0;
   logic              reset_i = 1'b0;
   logic [2:0]        req_i = '0;
   logic [2:0]        we_i = '0;
   logic [3*AW-1:0]   addr_i = '0;
   logic [47:0]       wdata_i = '0;
   logic [5:0]        dm_i = '0;
   logic [2:0]        ack_o;
   logic [15:0]       rdata_o;
   logic [2:0]        rvalid_o;
   logic              err_o;
   logic              mem_rd_o;
   logic              mem_wr_o;
   logic [AW-1:0]     mem_A_o;
   logic [15:0]       mem_D_o;
   logic [1:0]        mem_Dm_o;
   logic [15:0]       mem_D_i = '0;
   logic              mem_valid_i = 1'b0;

   int errors = 0;
   int checks = 0;

   sdram_arbiter #(.AW(AW), .WR_CYCLES(WR_CYCLES), .RD_TIMEOUT(RD_TIMEOUT)) dut (
      .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .dm_i(dm_i), .ack_o(ack_o), .rdata_o(rdata_o),
      .rvalid_o(rvalid_o), .err_o(err_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
      .mem_A_o(mem_A_o), .mem_D_o(mem_D_o), .mem_Dm_o(mem_Dm_o),
      .mem_D_i(mem_D_i), .mem_valid_i(mem_valid_i)
   );

   always #5 clk = ~clk;

   // lat: cycles after the strobe cycle at which mem_valid_i is given; -1 = never
   typedef struct {
      int          port;
      logic        we;
      logic [22:0] addr;
      logic [15:0] wdata;
      logic [1:0]  dm;
      int          lat;
      logic [15:0] rval;
      logic        err;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one port's fields; other ports get unrelated filler to catch slicing bugs.
   task automatic drive_port(input int p, input logic we, input logic [22:0] a,
                             input logic [15:0] d, input logic [1:0] m);
      for (int q = 0; q < 3; q++) begin
         addr_i[q*AW +: AW] = (q == p) ? a : (~a ^ 23'(q));
         wdata_i[q*16 +: 16] = (q == p) ? d : (~d ^ 16'(q));
         dm_i[q*2 +: 2]     = (q == p) ? m : ~m;
         we_i[q]            = (q == p) ? we : ~we;
      end
      req_i = 3'b001 << p;
   endtask

   task automatic do_reset();
      req_i = 3'b000;
      mem_valid_i = 1'b0;
      reset_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   task automatic do_txn(input vec_t v, input int idx);
      logic [2:0] oh;
      int n;
      oh = 3'b001 << v.port;
      drive_port(v.port, v.we, v.addr, v.wdata, v.dm);
      tick();
      chk("ack", ack_o, oh);
      chk("no_early_strobe", {mem_rd_o, mem_wr_o}, 2'b00);
      req_i = 3'b000;
      tick();
      chk("ack_pulse", ack_o, 3'b000);
      chk("rd_strobe", mem_rd_o, !v.we);
      chk("wr_strobe", mem_wr_o, v.we);
      chk("mem_addr", mem_A_o, v.addr);
      chk("mem_dm", mem_Dm_o, v.dm);
      if (v.we) begin
         chk("mem_data", mem_D_o, v.wdata);
         for (int c = 0; c < WR_CYCLES; c++) begin
            tick();
            chk("wr_strobe_once", {mem_rd_o, mem_wr_o}, 2'b00);
         end
         chk("addr_held", mem_A_o, v.addr);
         chk("data_held", mem_D_o, v.wdata);
      end else if (v.lat >= 0) begin
         for (int c = 0; c < v.lat; c++) begin
            tick();
            chk("no_early_rvalid", rvalid_o, 3'b000);
         end
         mem_valid_i = 1'b1;
         mem_D_i = v.rval;
         tick();
         mem_valid_i = 1'b0;
         mem_D_i = 16'h0BAD;
         chk("rvalid", rvalid_o, oh);
         chk("rdata", rdata_o, v.rval);
         chk("err", err_o, v.err);
         tick();
         chk("rvalid_pulse", rvalid_o, 3'b000);
      end else begin
         n = 0;
         while (rvalid_o == 3'b000 && n < 40) begin
            tick();
            n++;
         end
         chk("timeout_cycles", n, RD_TIMEOUT + 1);
         chk("timeout_rvalid", rvalid_o, oh);
         chk("timeout_rdata", rdata_o, 16'hFFFF);
         chk("timeout_err", err_o, 1'b1);
         tick();
         chk("err_sticky", err_o, 1'b1);
         chk("rvalid_pulse", rvalid_o, 3'b000);
      end
      $display("txn %0d: port %0d %s addr=%06h rdata=%04h err=%0d", idx, v.port,
               v.we ? "write" : "read", v.addr, rdata_o, err_o);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] exp_order [4];
      int n;

      vecs[0] = '{port: 1, we: 1'b0, addr: 23'h000123, wdata: 16'h1111, dm: 2'b00, lat: 5,  rval: 16'hBEEF, err: 1'b0};
      vecs[1] = '{port: 2, we: 1'b1, addr: 23'h7FFFFF, wdata: 16'h1234, dm: 2'b01, lat: 0,  rval: 16'h0000, err: 1'b0};
      vecs[2] = '{port: 0, we: 1'b0, addr: 23'h000000, wdata: 16'h2222, dm: 2'b11, lat: 0,  rval: 16'h0001, err: 1'b0};
      vecs[3] = '{port: 0, we: 1'b1, addr: 23'h2AAAAA, wdata: 16'hA5A5, dm: 2'b10, lat: 0,  rval: 16'h0000, err: 1'b0};
      vecs[4] = '{port: 1, we: 1'b1, addr: 23'h155555, wdata: 16'hFFFF, dm: 2'b11, lat: 0,  rval: 16'h0000, err: 1'b0};
      vecs[5] = '{port: 2, we: 1'b0, addr: 23'h400000, wdata: 16'h3333, dm: 2'b00, lat: RD_TIMEOUT, rval: 16'hC3C3, err: 1'b0};
      vecs[6] = '{port: 1, we: 1'b0, addr: 23'h000777, wdata: 16'h4444, dm: 2'b01, lat: -1, rval: 16'h0000, err: 1'b1};
      vecs[7] = '{port: 0, we: 1'b0, addr: 23'h000010, wdata: 16'h5555, dm: 2'b10, lat: 2,  rval: 16'h5A5A, err: 1'b1};

`ifdef SDRAM_ARB_RR_EN
      exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
      exp_order = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif

      // Reset state
      do_reset();
      chk("rst_ack", ack_o, 3'b000);
      chk("rst_rvalid", rvalid_o, 3'b000);
      chk("rst_strobes", {mem_rd_o, mem_wr_o}, 2'b00);
      chk("rst_addr", mem_A_o, 23'h0);
      chk("rst_data", mem_D_o, 16'h0);
      chk("rst_dm", mem_Dm_o, 2'b00);
      chk("rst_rdata", rdata_o, 16'h0);
      chk("rst_err", err_o, 1'b0);

      // Table of single-port transactions
      for (int i = 0; i < 8; i++) begin
         do_txn(vecs[i], i);
      end

      // Reset during WAIT_RD, late mem_valid_i must be ignored
      drive_port(1, 1'b0, 23'h000456, 16'h0, 2'b00);
      tick();
      req_i = 3'b000;
      tick();
      repeat (3) tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      chk("midrst_ack", ack_o, 3'b000);
      chk("midrst_strobes", {mem_rd_o, mem_wr_o}, 2'b00);
      chk("midrst_addr", mem_A_o, 23'h0);
      chk("midrst_data", mem_D_o, 16'h0);
      chk("midrst_dm", mem_Dm_o, 2'b00);
      chk("midrst_err", err_o, 1'b0);
      mem_valid_i = 1'b1;
      mem_D_i = 16'hABCD;
      tick();
      mem_valid_i = 1'b0;
      chk("midrst_rvalid", rvalid_o, 3'b000);
      chk("midrst_rdata", rdata_o, 16'h0);
      tick();
      chk("midrst_rvalid2", rvalid_o, 3'b000);
      $display("txn reset-in-read: rdata=%04h err=%0d", rdata_o, err_o);

      // Write-to-grant spacing: port 0 read requested right after a port 2 write ack
      drive_port(2, 1'b1, 23'h7FFFFF, 16'h1234, 2'b01);
      tick();
      chk("sp_ack_wr", ack_o, 3'b100);
      drive_port(0, 1'b0, 23'h000042, 16'h0, 2'b00);
      n = 0;
      do begin
         tick();
         n++;
      end while (ack_o == 3'b000 && n < 20);
      chk("wr_spacing", n, WR_CYCLES + 2);
      chk("sp_ack_rd", ack_o, 3'b001);
      req_i = 3'b000;
      tick();
      chk("sp_rd_strobe", mem_rd_o, 1'b1);
      chk("sp_rd_addr", mem_A_o, 23'h000042);
      mem_valid_i = 1'b1;
      mem_D_i = 16'h2222;
      tick();
      mem_valid_i = 1'b0;
      chk("sp_rvalid", rvalid_o, 3'b001);
      chk("sp_rdata", rdata_o, 16'h2222);
      tick();
      $display("txn spacing: write->read grant gap %0d cycles", n);

      // Spurious mem_valid_i in IDLE and in WAIT_WR
      mem_valid_i = 1'b1;
      mem_D_i = 16'hDEAD;
      tick();
      mem_valid_i = 1'b0;
      chk("spur_idle_rvalid", rvalid_o, 3'b000);
      chk("spur_idle_rdata", rdata_o, 16'h2222);
      drive_port(1, 1'b1, 23'h001000, 16'h7777, 2'b10);
      tick();
      req_i = 3'b000;
      tick();
      chk("spur_wr_strobe", mem_wr_o, 1'b1);
      mem_valid_i = 1'b1;
      mem_D_i = 16'hDEAD;
      tick();
      mem_valid_i = 1'b0;
      chk("spur_wr_rvalid", rvalid_o, 3'b000);
      chk("spur_wr_rdata", rdata_o, 16'h2222);
      repeat (WR_CYCLES) tick();
      $display("txn spurious-valid: rdata=%04h", rdata_o);

      // All ports requesting reads continuously
      do_reset();
      for (int q = 0; q < 3; q++) begin
         addr_i[q*AW +: AW] = 23'(q + 16);
      end
      we_i = 3'b000;
      req_i = 3'b111;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         while (ack_o == 3'b000 && n < 20) begin
            tick();
            n++;
         end
         chk("grant_order", ack_o, exp_order[g]);
         tick();
         chk("arb_rd_strobe", mem_rd_o, 1'b1);
         mem_valid_i = 1'b1;
         mem_D_i = 16'(g + 16'h100);
         tick();
         mem_valid_i = 1'b0;
         chk("arb_rvalid", rvalid_o, exp_order[g]);
         $display("txn arb %0d: granted %b rdata=%04h", g, exp_order[g], rdata_o);
      end
      req_i = 3'b000;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
